// File: rtl/atlas_pkg.sv
// atlas_pkg: shared sample types, frame size and hold-bank states for the audio capture path
package atlas_pkg;
    localparam int SAMPLE_W = 24;
    localparam int FRAME_N  = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {EMPTY, READY, BUSY} hold_state_t;

    // Average of left and right; one extra bit keeps the sum from overflowing
    function automatic logic signed [SAMPLE_W:0] mix_mono(input sample_t l, input sample_t r);
        logic signed [SAMPLE_W:0] sum;
        sum = {l[SAMPLE_W-1], l} + {r[SAMPLE_W-1], r};
        return sum >>> 1;
    endfunction
endpackage

// File: rtl/frame_ram.sv
// frame_ram: two-bank sample store, one write port and one registered read port
module frame_ram #(
    parameter int N     = 32,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(2 * N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [2*N];

    // write port; address is {bank, index}
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // registered read, cleared by reset so the output starts at zero
    always_ff @(posedge clk) begin
        rd_data <= reset ? '0 : mem[rd_addr];
    end
endmodule

// File: rtl/sample_framer.sv
// sample_framer: mixes i2s stereo pairs to mono and hands full frames to a consumer
module sample_framer
    import atlas_pkg::*;
#(
    parameter int N     = FRAME_N,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lrck,
    input  sample_t          left,
    input  sample_t          right,
    output logic             frame_ready,
    input  logic             frame_start,
    input  logic             frame_done,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [7:0]       overruns
);
    logic                     lrck_q;
    logic [AW-1:0]            wr_addr_q, wr_addr_d;
    logic                     wr_bank_q, wr_bank_d;
    hold_state_t              state_q, state_d, state_mid;
    logic                     frame_ready_q, frame_ready_d;
    logic [7:0]               overruns_q, overruns_d;
    logic                     capture, fill, swap;
    logic signed [SAMPLE_W:0] mono;
    logic                     unused_mono;

    assign capture     = lrck_q & ~lrck;
    assign fill        = capture && (wr_addr_q == AW'(N - 1));
    assign mono        = mix_mono(left, right);
    assign unused_mono = ^mono;
    assign frame_ready = frame_ready_q;
    assign overruns    = overruns_q;

    // next state: a release is applied before a simultaneous fill is judged
    always_comb begin
        state_mid     = (state_q == BUSY && frame_done) ? EMPTY : state_q;
        swap          = fill && state_mid == EMPTY;
        state_d       = swap ? READY : (state_mid == READY && frame_start) ? BUSY : state_mid;
        wr_addr_d     = !capture ? wr_addr_q : fill ? '0 : wr_addr_q + AW'(1);
        wr_bank_d     = wr_bank_q ^ swap;
        overruns_d    = (fill && !swap && overruns_q != 8'hFF) ? overruns_q + 8'd1 : overruns_q;
        frame_ready_d = state_d == READY;
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            lrck_q        <= 1'b0;
            wr_addr_q     <= '0;
            wr_bank_q     <= 1'b0;
            state_q       <= EMPTY;
            frame_ready_q <= 1'b0;
            overruns_q    <= '0;
        end else begin
            lrck_q        <= lrck;
            wr_addr_q     <= wr_addr_d;
            wr_bank_q     <= wr_bank_d;
            state_q       <= state_d;
            frame_ready_q <= frame_ready_d;
            overruns_q    <= overruns_d;
        end
    end

    frame_ram #(.N(N), .WIDTH(WIDTH)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (capture),
        .wr_addr ({wr_bank_q, wr_addr_q}),
        .wr_data (mono[SAMPLE_W-1 -: WIDTH]),
        .rd_addr ({~wr_bank_q, rd_addr}),
        .rd_data (rd_data)
    );
endmodule
